// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 fetch stage: the queue entry layout
// and the default datapath width the entry is built from.
package fetch_pkg;

    localparam int DEFAULT_XLEN = 32;

    // Word held by an allocated slot until its response arrives.
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [31:0]             instr;
        logic                    pred_taken;
        logic [DEFAULT_XLEN-1:0] pred_target;
        logic                    filled;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch buffer: slots are allocated at issue, filled in order as memory
// responses return, and popped from the head by decode. Flush empties it at once.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    alloc_i,
    input  logic [DEFAULT_XLEN-1:0] alloc_pc_i,
    input  logic                    alloc_taken_i,
    input  logic [DEFAULT_XLEN-1:0] alloc_target_i,
    input  logic                    fill_i,
    input  logic [31:0]             fill_instr_i,
    input  logic                    pop_i,
    output fq_entry_t               head_o,
    output logic [CW-1:0]           alloc_cnt_o,
    output logic [CW-1:0]           unfilled_cnt_o
);

    fq_entry_t     slot_q [DEPTH];
    logic [PW-1:0] alloc_ptr_q;
    logic [PW-1:0] fill_ptr_q;
    logic [PW-1:0] pop_ptr_q;
    logic [CW-1:0] alloc_cnt_q,    alloc_cnt_d;
    logic [CW-1:0] unfilled_cnt_q, unfilled_cnt_d;
    logic          fill_fire;

    assign fill_fire = fill_i && (unfilled_cnt_q != '0);

    always_comb begin
        // NOTE: defaults first so every path assigns; otherwise a latch is inferred.
        alloc_cnt_d    = alloc_cnt_q;
        unfilled_cnt_d = unfilled_cnt_q;
        if (flush_i) begin
            alloc_cnt_d    = '0;
            unfilled_cnt_d = '0;
        end else begin
            alloc_cnt_d    = alloc_cnt_q + CW'(alloc_i) - CW'(pop_i);
            unfilled_cnt_d = unfilled_cnt_q + CW'(alloc_i) - CW'(fill_fire);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_ptr_q    <= '0;
            fill_ptr_q     <= '0;
            pop_ptr_q      <= '0;
            alloc_cnt_q    <= '0;
            unfilled_cnt_q <= '0;
        end else if (flush_i) begin
            alloc_ptr_q    <= '0;
            fill_ptr_q     <= '0;
            pop_ptr_q      <= '0;
            alloc_cnt_q    <= '0;
            unfilled_cnt_q <= '0;
        end else begin
            if (alloc_i)   alloc_ptr_q <= alloc_ptr_q + PW'(1);
            if (fill_fire) fill_ptr_q  <= fill_ptr_q + PW'(1);
            if (pop_i)     pop_ptr_q   <= pop_ptr_q + PW'(1);
            alloc_cnt_q    <= alloc_cnt_d;
            unfilled_cnt_q <= unfilled_cnt_d;
        end
    end

    // NOTE: slot payload is not reset; a slot is only read while allocated, and
    // allocation rewrites the whole entry including the filled flag.
    always_ff @(posedge clk) begin
        if (alloc_i && !flush_i) begin
            slot_q[alloc_ptr_q] <= '{pc:          alloc_pc_i,
                                     instr:       INSTR_NOP,
                                     pred_taken:  alloc_taken_i,
                                     pred_target: alloc_target_i,
                                     filled:      1'b0};
        end
        if (fill_fire && !flush_i) begin
            slot_q[fill_ptr_q].instr  <= fill_instr_i;
            slot_q[fill_ptr_q].filled <= 1'b1;
        end
    end

    assign head_o         = slot_q[pop_ptr_q];
    assign alloc_cnt_o    = alloc_cnt_q;
    assign unfilled_cnt_o = unfilled_cnt_q;

    a_no_alloc_when_full: assert property (@(posedge clk) disable iff (!rst)
        alloc_i |-> (alloc_cnt_q != CW'(DEPTH)));

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst)
        pop_i |-> (alloc_cnt_q != '0));

endmodule

// File: rtl/fetch_unit_q.sv
// RV32 fetch stage: PC register with redirect/BTB/sequential next-PC mux, credit-
// limited issue to a variable-latency in-order memory, and stale-response dropping.
module fetch_unit_q
    import fetch_pkg::*;
#(
    parameter int              XLEN        = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              FETCH_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] btb_lookup_pc,
    input  logic            btb_hit,
    input  logic            btb_taken,
    input  logic [XLEN-1:0] btb_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic            dec_pred_taken,
    output logic [XLEN-1:0] dec_pred_target
);

    localparam int           CW      = $clog2(FETCH_DEPTH) + 1;
    localparam int           SW      = CW + 1;
    localparam logic [SW-1:0] DEPTH_W = SW'(FETCH_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   alloc_cnt;
    logic [CW-1:0]   unfilled_cnt;
    logic [SW-1:0]   outstanding;
    fq_entry_t       head;
    logic            credit_ok;
    logic            req_fire;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            rsp_drop;
    logic            rsp_fill;
    logic            rsp_consumed;
    logic            pop;
    logic            unused_low_bits;

    assign unused_low_bits = ^{redirect_pc[1:0], btb_target[1:0]};

    // Every accepted request owns either a queue slot or a drop credit until its
    // response returns, so the sum bounds in-flight plus buffered fetches.
    assign outstanding = {1'b0, unfilled_cnt} + {1'b0, drop_cnt_q};
    assign credit_ok   = ({1'b0, alloc_cnt} + {1'b0, drop_cnt_q}) < DEPTH_W;

    assign imem_req_valid = rst && fetch_en && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc_q;
    assign btb_lookup_pc  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign pred_taken  = btb_hit && btb_taken;
    assign pred_target = pred_taken ? {btb_target[XLEN-1:2], 2'b00} : '0;

    assign rsp_drop     = imem_rsp_valid && (drop_cnt_q != '0);
    assign rsp_fill     = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
    assign rsp_consumed = imem_rsp_valid && (outstanding != '0);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (req_fire) begin
            pc_d = pred_taken ? pred_target : pc_q + XLEN'(4);
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            drop_cnt_d = CW'(outstanding - SW'(rsp_consumed));
        end else if (rsp_drop) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= {RESET_PC[XLEN-1:2], 2'b00};
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_queue #(
        .DEPTH (FETCH_DEPTH)
    ) u_queue (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (redirect_valid),
        .alloc_i        (req_fire),
        .alloc_pc_i     (pc_q),
        .alloc_taken_i  (pred_taken),
        .alloc_target_i (pred_target),
        .fill_i         (rsp_fill),
        .fill_instr_i   (imem_rsp_data),
        .pop_i          (pop),
        .head_o         (head),
        .alloc_cnt_o    (alloc_cnt),
        .unfilled_cnt_o (unfilled_cnt)
    );

    assign dec_valid       = (alloc_cnt != '0) && head.filled && !redirect_valid;
    assign pop             = dec_valid && dec_ready;
    assign dec_instr       = dec_valid ? head.instr       : '0;
    assign dec_pc          = dec_valid ? head.pc          : '0;
    assign dec_pred_taken  = dec_valid && head.pred_taken;
    assign dec_pred_target = dec_valid ? head.pred_target : '0;

    // A response with nothing outstanding is a memory protocol error; it is ignored.
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: doc/fetch_unit_q.md
Name: fetch_unit_q

Overview:
- Parametrised next-generation fetch stage for the RV32 core.
- Generates the fetch PC from redirect, BTB prediction or sequential increment.
- Issues requests to an instruction memory with variable latency and in-order responses.
- Buffers fetched instructions in a FETCH_DEPTH-entry queue with a valid/ready handshake to decode; a redirect flushes the queue and discards stale responses.

Parameters:
- XLEN, 32, PC/data width.
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- FETCH_DEPTH, 4, queue slots; power of two, >=2; bounds outstanding plus buffered fetches.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- fetch_en  in  1  permits new memory requests.
- redirect_valid  in  1  flush and redirect, from execute (mispredict or jump).
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored.
- btb_lookup_pc  out  XLEN  current fetch PC for the external BTB.
- btb_hit  in  1  BTB entry valid for btb_lookup_pc.
- btb_taken  in  1  predicted taken.
- btb_target  in  XLEN  predicted target.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response; in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- dec_valid  out  1  queue head holds a filled instruction.
- dec_ready  in  1  decode accepts.
- dec_instr  out  32  instruction.
- dec_pc  out  XLEN  PC of the instruction.
- dec_pred_taken  out  1  BTB taken prediction made at fetch.
- dec_pred_target  out  XLEN  predicted target; 0 when not taken.

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, queue empty, drop_cnt=0. All outputs are 0 except imem_req_addr=btb_lookup_pc=RESET_PC.
- imem_req_addr = btb_lookup_pc = pc, with pc[1:0] always 0.
- imem_req_valid = fetch_en & !redirect_valid & (alloc_cnt + drop_cnt < FETCH_DEPTH).
- Request acceptance (valid & ready):
  - Allocate a slot at the tail holding {pc, pred_taken, pred_target, filled=0}.
  - pred_taken = btb_hit & btb_taken.
  - pc <= pred_taken ? {btb_target[XLEN-1:2],2'b00} : pc+4. The increment wraps modulo 2^XLEN.
- Request not accepted: pc and the address are held stable while imem_req_valid=1.
- Response handling:
  - If drop_cnt > 0: decrement drop_cnt and discard the data.
  - Otherwise: write instr into the oldest unfilled slot and set filled=1.
  - A response with no unfilled slot and drop_cnt=0 is a protocol error: ignored, and an assertion fires.
- dec_valid = head allocated & head filled & !redirect_valid. Pop on dec_valid & dec_ready.
- Fill-to-dec_valid latency is 1 cycle: the registered fill is visible the next cycle. Same-cycle fill of a non-head slot and pop of the head are legal.
- Redirect (highest priority):
  - Next cycle the queue is empty and pc = {redirect_pc[XLEN-1:2],2'b00}.
  - drop_cnt <= unfilled allocated slots + drop_cnt - (imem_rsp_valid ? 1 : 0).
  - No request is issued and no pop occurs in the redirect cycle.
- Back-to-back redirects: the last one wins; drop counts accumulate correctly.
- fetch_en=0: issuing stops; in-flight responses still fill and the queue drains.
- Queue full (alloc_cnt=FETCH_DEPTH): no issue. Issue resumes the cycle after a pop.
- Pointers are $clog2(FETCH_DEPTH) bits with wrap-around. Counts are $clog2(FETCH_DEPTH)+1 bits.
- Reset mid-operation clears everything. The memory shares rst, so no stale response may arrive after reset.

Decomposition:
- fetch_pkg:
  - XLEN default.
  - fq_entry_t {pc, instr, pred_taken, pred_target, filled}.
  - INSTR_NOP = 32'h0000_0013.
- Sub-module fetch_queue:
  - Circular buffer with alloc, fill and pop pointers, a flush input, alloc_cnt and unfilled_cnt outputs.
- Top level holds the PC register, next-PC mux, issue credit logic and drop_cnt.

Test Plan:
- Reset: hold rst=0 -> imem_req_addr=0, dec_valid=0. Release with memory latency 1 and dec_ready=1 -> requests 0x0,0x4,0x8,0xC, and decode receives matching pc/instr in order.
- Backpressure: FETCH_DEPTH=4, dec_ready=0, memory latency 3 -> exactly 4 requests, then imem_req_valid=0. Set dec_ready=1 -> pcs 0x0..0xC delivered, one per cycle; issue resumes.
- BTB: btb_hit=btb_taken=1 with target 0x100 at pc 0x8 -> next request 0x100. The slot for 0x8 shows dec_pred_taken=1, dec_pred_target=0x100.
- Flush: 2 unfilled slots, redirect_pc=0x203 -> next-cycle dec_valid=0. The next 2 responses are dropped; the first delivered instruction has dec_pc=0x200 and the third response's data.
- Memory stall: imem_req_ready=0 for 5 cycles -> imem_req_addr stable and pc unchanged. A redirect during the stall replaces the address.
- Async reset mid-operation: assert rst between clock edges with a full queue -> outputs reset immediately, and the queue is empty after release.
